// File: rtl/fifo_defines_pkg.sv
// -----------------------------------------------------------------------------
// fifo_defines_pkg
// Shared definitions for the function-generator sample FIFO.
//   DATA_WIDTH     : sample width (signed two's complement)
//   FIFO_DEPTH     : default number of FIFO entries (power of 2, >= 4)
//   FIFO_AF_THRESH : default almost-full threshold (occupancy >= threshold)
// -----------------------------------------------------------------------------
package fifo_defines_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_AF_THRESH = FIFO_DEPTH - 2;

    // Per-cycle handshake outcome: which of the requested operations the
    // FIFO actually performs.
    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_acc_t;

    // True when n is a legal FIFO depth (power of two, at least 4).
    function automatic bit fifo_depth_ok(input int n);
        return (n >= 4) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/gen_fifo_mem.sv
// -----------------------------------------------------------------------------
// gen_fifo_mem
// DEPTH x DATA_WIDTH register array with one write port and one registered
// read port. The array itself is not reset; only the read register is.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears the read register only)
//   we    : write enable
//   waddr : write address
//   wdata : write data (signed)
//   re    : read enable; rdata loads mem[raddr] on the next edge
//   raddr : read address
//   rdata : registered read data; holds its value when re is low
// -----------------------------------------------------------------------------
module gen_fifo_mem #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] rdata_q;
    logic signed [DATA_WIDTH-1:0] rdata_d;

    // Storage array: no reset so it maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read and a write to the same address in one cycle returns the old
    // contents, which is what keeps FIFO order when full with wr+rd.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gen_sample_fifo.sv
// -----------------------------------------------------------------------------
// gen_sample_fifo
// Sample buffer placed directly after funct_generator. Stores each sample on
// the generator write strobe, returns it on a consumer read with one cycle of
// latency, and exposes full / almost-full back-pressure plus sticky
// overflow / underflow debug flags.
//   clk           : clock, all state changes on the rising edge
//   rst           : asynchronous active-low reset
//   clr_i         : synchronous flush (empties FIFO, clears sticky flags)
//   wr_en_i       : write strobe (generator wr_en_o)
//   data_i        : signed sample (generator data_o)
//   rd_en_i       : consumer read request
//   data_o        : registered read data (signed)
//   valid_o       : data_o holds a sample read on the previous edge
//   empty_o       : count == 0
//   full_o        : count == DEPTH
//   almost_full_o : count >= AF_THRESH
//   count_o       : occupancy 0..DEPTH
//   overflow_o    : sticky, write while full without a read
//   underflow_o   : sticky, read while empty
// -----------------------------------------------------------------------------
module gen_sample_fifo
    import fifo_defines_pkg::*;
#(
    parameter  int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
    parameter  int DEPTH      = FIFO_DEPTH,
    parameter  int AF_THRESH  = DEPTH - 2,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         rd_en_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic [PTR_W:0]               count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W + 1)'(AF_THRESH);

    // Pointers carry one extra wrap bit so occupancy is their difference.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q,  count_d;
    logic           valid_q,  valid_d;
    logic           ovf_q,    ovf_d;
    logic           unf_q,    unf_d;

    logic           empty;
    logic           full;
    fifo_acc_t      acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Reads never fall through an empty FIFO; a write into a full FIFO is
    // only taken when a read frees a slot in the same cycle. Flush wins.
    always_comb begin
        acc.rd = rd_en_i && !empty && !clr_i;
        acc.wr = wr_en_i && (!full || acc.rd) && !clr_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = acc.rd;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (acc.wr) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (acc.rd) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
            unique case ({acc.wr, acc.rd})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            // Full with a simultaneous read is not an overflow.
            if (wr_en_i && full && !rd_en_i) begin
                ovf_d = 1'b1;
            end
            // Includes the empty + wr + rd case, where the read is refused.
            if (rd_en_i && empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    gen_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (acc.wr),
        .waddr (wr_ptr_q[PTR_W-1:0]),
        .wdata (data_i),
        .re    (acc.rd),
        .raddr (rd_ptr_q[PTR_W-1:0]),
        .rdata (data_o)
    );

    assign valid_o       = valid_q;
    assign empty_o       = empty;
    assign full_o        = full;
    assign almost_full_o = (count_q >= AF_C);
    assign count_o       = count_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

    // Structural invariants of the pointer/count bookkeeping.
    a_count_ptr: assert property (@(posedge clk) disable iff (!rst)
        count_q == (wr_ptr_q - rd_ptr_q));
    a_not_empty_full: assert property (@(posedge clk) disable iff (!rst)
        !(empty_o && full_o));
    a_count_max: assert property (@(posedge clk) disable iff (!rst)
        count_q <= DEPTH_C);

endmodule

// File: tb/tb_gen_sample_fifo.sv
module tb_gen_sample_fifo;
    import fifo_defines_pkg::*;

    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH);

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b0;
    logic                 clr_i   = 1'b0;
    logic                 wr_en_i = 1'b0;
    logic                 rd_en_i = 1'b0;
    logic signed [DW-1:0] data_i  = '0;
    logic signed [DW-1:0] data_o;
    logic                 valid_o;
    logic                 empty_o;
    logic                 full_o;
    logic                 almost_full_o;
    logic [PW:0]          count_o;
    logic                 overflow_o;
    logic                 underflow_o;

    gen_sample_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (DEPTH - 2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr_i),
        .wr_en_i       (wr_en_i),
        .data_i        (data_i),
        .rd_en_i       (rd_en_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stored samples, expected read results, sticky flags.
    logic signed [DW-1:0] mq[$];
    logic signed [DW-1:0] sb[$];
    logic signed [DW-1:0] m_last = '0;
    bit                   m_valid = 1'b0;
    bit                   m_ovf = 1'b0;
    bit                   m_unf = 1'b0;

    typedef struct {
        bit                   wr;
        bit                   rd;
        bit                   clr;
        logic signed [DW-1:0] d;
        int                   reps;
        int                   e_cnt;
        bit                   e_vld;
        bit                   e_ovf;
        bit                   e_unf;
        logic signed [DW-1:0] e_data;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("valid_o", valid_o, m_valid);
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: valid_o with no expected sample at %0t", $time);
            end else begin
                m_last = sb.pop_front();
            end
        end
        chk("data_o", data_o, m_last);
        chk("count_o", count_o, mq.size());
        chk("empty_o", empty_o, mq.size() == 0);
        chk("full_o", full_o, mq.size() == DEPTH);
        chk("almost_full_o", almost_full_o, mq.size() >= DEPTH - 2);
        chk("overflow_o", overflow_o, m_ovf);
        chk("underflow_o", underflow_o, m_unf);
    endtask

    // Drive one cycle starting at a falling edge, update the model, then
    // compare at the next falling edge.
    task automatic step(input bit wr, input bit rd, input bit clr,
                        input logic signed [DW-1:0] d);
        bit ra;
        bit wa;
        wr_en_i = wr;
        rd_en_i = rd;
        clr_i   = clr;
        data_i  = d;
        if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            ra = rd && (mq.size() != 0);
            wa = wr && ((mq.size() < DEPTH) || ra);
            if (rd && mq.size() == 0) m_unf = 1'b1;
            if (wr && mq.size() == DEPTH && !rd) m_ovf = 1'b1;
            if (ra) sb.push_back(mq.pop_front());
            if (wa) mq.push_back(d);
            m_valid = ra;
        end
        @(negedge clk);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clr_i   = 1'b0;
        chk_model();
    endtask

    function automatic vec_t mk(input bit wr, input bit rd, input bit clr,
                                input logic signed [DW-1:0] d, input int reps,
                                input int e_cnt, input bit e_vld, input bit e_ovf,
                                input bit e_unf, input logic signed [DW-1:0] e_data);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.d = d; v.reps = reps;
        v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_ovf = e_ovf; v.e_unf = e_unf;
        v.e_data = e_data;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                wr    rd    clr   data          reps cnt vld   ovf   unf   last data
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh0001,    1,   1, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, -16'sd1,      1,   2, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh7FFF,    1,   3, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 16'sh0000,    3,   0, 1'b1, 1'b0, 1'b0, 16'sh7FFF));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh0100,   16,  16, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh7777,    1,  16, 1'b0, 1'b1, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 16'sh0000,    1,  15, 1'b1, 1'b1, 1'b0, 16'sh0100));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 16'sh0000,    1,   0, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh0400,   16,  16, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b1, 1'b0, 16'sh0500,    8,  16, 1'b1, 1'b0, 1'b0, 16'sh0407));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 16'sh0000,   16,   0, 1'b1, 1'b0, 1'b0, 16'sh0507));
        vt.push_back(mk(1'b1, 1'b1, 1'b0, 16'sh1234,    1,   1, 1'b0, 1'b0, 1'b1, 16'sh0000));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 16'sh0000,    1,   0, 1'b1, 1'b0, 1'b1, 16'sh1234));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh0600,   16,  16, 1'b0, 1'b0, 1'b1, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh6666,    1,  16, 1'b0, 1'b1, 1'b1, 16'sh0000));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 16'sh0000,   11,   5, 1'b1, 1'b1, 1'b1, 16'sh060A));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 16'sh0000,    1,   0, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 16'sh0700,    1,   1, 1'b0, 1'b0, 1'b0, 16'sh0000));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 16'sh0701,    1,   0, 1'b0, 1'b0, 1'b0, 16'sh0000));

        // Reset held for two cycles, checked while asserted and after release.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold count_o", count_o, 0);
        chk("rst_hold empty_o", empty_o, 1);
        chk("rst_hold valid_o", valid_o, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_model();

        for (int v = 0; v < vt.size(); v++) begin
            for (int r = 0; r < vt[v].reps; r++) begin
                step(vt[v].wr, vt[v].rd, vt[v].clr, vt[v].d + DW'(r));
            end
            chk($sformatf("vec%0d count_o", v), count_o, vt[v].e_cnt);
            chk($sformatf("vec%0d valid_o", v), valid_o, vt[v].e_vld);
            chk($sformatf("vec%0d overflow_o", v), overflow_o, vt[v].e_ovf);
            chk($sformatf("vec%0d underflow_o", v), underflow_o, vt[v].e_unf);
            if (vt[v].e_vld) begin
                chk($sformatf("vec%0d data_o", v), data_o, vt[v].e_data);
            end
        end

        // Asynchronous reset landing just after a read edge.
        step(1'b1, 1'b0, 1'b0, 16'sh0A01);
        step(1'b1, 1'b0, 1'b0, 16'sh0A02);
        rd_en_i = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst valid_o", valid_o, 0);
        chk("midrst count_o", count_o, 0);
        chk("midrst empty_o", empty_o, 1);
        chk("midrst data_o", data_o, 0);
        rd_en_i = 1'b0;
        mq.delete();
        sb.delete();
        m_last  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'sh0000);
        step(1'b1, 1'b0, 1'b0, -16'sd300);
        step(1'b0, 1'b1, 1'b0, 16'sh0000);
        chk("postrst data_o", data_o, -300);
        step(1'b0, 1'b0, 1'b0, 16'sh0000);
        chk("postrst hold data_o", data_o, -300);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
